apb_req_sequencer: RTL and testbench

Upstream stage of apb_master. Accepts simple valid/ready command requests (read or write), buffers them in a small FIFO, and converts each into a compliant APB SETUP/ACCESS sequence on the psel/penable/paddr/pwrite/pprot/pwdata/pstrb lines that apb_master consumes. Captures prdata/pslverr on pready and returns one response per command over a valid/ready response channel. Adds slave decode, alignment checking and an access timeout.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_cmd_fifo.sv | 64 ++++++
 rtl/apb_req_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_apb_req_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB request sequencer and its command FIFO.
package apb_pkg;

  localparam int APB_AW  = 32;
  localparam int APB_DW  = 32;
  localparam int NUM_SLV = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_AW-1:0]   addr;
    logic                write;
    logic [APB_DW-1:0]   wdata;
    logic [APB_DW/8-1:0] strb;
    logic [2:0]          prot;
  } apb_cmd_t;

  // Word-aligned byte address check; misaligned commands never reach the bus.
  function automatic logic is_aligned(input logic [APB_AW-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous FIFO holding pending commands. Push is ignored when full
// (even if a pop happens in the same cycle); pop is ignored when empty.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge pclk) begin
    if (push_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/apb_req_sequencer.sv
// Turns queued valid/ready commands into APB SETUP/ACCESS transfers and
// returns one response per command.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for a queued command; pops head, checks alignment
//  ST_SETUP  | psel high, penable low for one cycle; arms timeout counter
//  ST_ACCESS | penable high, waiting for pready or timeout expiry
//  ST_RESP   | response held on rsp_* until rsp_ready
module apb_req_sequencer
  import apb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SEL_LSB        = 12
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [APB_AW-1:0]  cmd_addr,
  input  logic               cmd_write,
  input  logic [APB_DW-1:0]  cmd_wdata,
  input  logic [3:0]         cmd_strb,
  input  logic [2:0]         cmd_prot,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [APB_DW-1:0]  rsp_rdata,
  output logic               rsp_slverr,
  output logic               rsp_timeout,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic [APB_AW-1:0]  paddr,
  output logic               pwrite,
  output logic [2:0]         pprot,
  output logic [APB_DW-1:0]  pwdata,
  output logic [3:0]         pstrb,
  input  logic [APB_DW-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int CMD_W = $bits(apb_cmd_t);
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  apb_cmd_t   cmd_in, head;
  logic [CMD_W-1:0] fifo_rd_data;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [1:0] slv_idx;

  apb_state_e         state_q, state_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [APB_AW-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [2:0]         pprot_q, pprot_d;
  logic [APB_DW-1:0]  pwdata_q, pwdata_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_slverr_q, rsp_slverr_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;

  // Ready is held low during reset so nothing is accepted while the FIFO clears.
  assign cmd_ready = ~fifo_full & ~preset;
  assign fifo_push = cmd_valid & cmd_ready;

  assign cmd_in = '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata,
                    strb: cmd_strb, prot: cmd_prot};
  assign head    = apb_cmd_t'(fifo_rd_data);
  assign slv_idx = head.addr[SEL_LSB+1:SEL_LSB];

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .pclk    (pclk),
    .preset  (preset),
    .push    (fifo_push),
    .wr_data (CMD_W'(cmd_in)),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state and next-output logic; every output holds unless a transition updates it.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pprot_d       = pprot_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!is_aligned(head.addr)) begin
            rsp_valid_d   = 1'b1;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
            state_d       = ST_RESP;
          end else begin
            paddr_d   = head.addr;
            pwrite_d  = head.write;
            pprot_d   = head.prot;
            pwdata_d  = head.wdata;
            pstrb_d   = head.write ? head.strb : 4'b0000;
            psel_d    = NUM_SLV'(1) << slv_idx;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        tmo_cnt_d = TMO_LOAD;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = '0;
          penable_d     = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_cnt_q == '0) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = '0;
          penable_d     = 1'b0;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, registered APB/response outputs and timeout counter.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pprot_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pprot_q       <= pprot_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pprot       = pprot_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_sequencer.sv
// Directed bench for apb_req_sequencer: single write, waited read, timeout,
// misaligned command, full-FIFO back-pressure/drain and reset mid-transfer.
module tb_apb_req_sequencer;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_write;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  apb_req_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16),
    .SEL_LSB        (12)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pprot       (pprot),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  logic [31:0] addr_tab [5];
  logic [31:0] rd_tab   [5];
  int          n_rsp;
  int          acc_cycles;
  logic        activity;

  initial begin
    addr_tab[0] = 32'h0000_0100; rd_tab[0] = 32'h1111_0000;
    addr_tab[1] = 32'h0000_1104; rd_tab[1] = 32'h2222_0001;
    addr_tab[2] = 32'h0000_2208; rd_tab[2] = 32'h3333_0002;
    addr_tab[3] = 32'h0000_330C; rd_tab[3] = 32'h4444_0003;
    addr_tab[4] = 32'h0000_0410; rd_tab[4] = 32'h5555_0004;

    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // ---------------- reset state
    tick(); tick();
    chk("rst_psel", psel, 4'h0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    preset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // ---------------- single write, pready high
    pready = 1'b1;
    set_cmd(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
    tick();                      // edge 0: accepted
    cmd_valid = 1'b0;
    chk("wr_e0_psel", psel, 4'h0);
    tick();                      // edge 1: SETUP
    chk("wr_setup_psel", psel, 4'b0010);
    chk("wr_setup_penable", penable, 1'b0);
    chk("wr_setup_paddr", paddr, 32'h0000_1004);
    tick();                      // edge 2: ACCESS
    chk("wr_acc_psel", psel, 4'b0010);
    chk("wr_acc_penable", penable, 1'b1);
    chk("wr_acc_pwrite", pwrite, 1'b1);
    chk("wr_acc_pstrb", pstrb, 4'hF);
    chk("wr_acc_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_acc_pprot", pprot, 3'b010);
    tick();                      // edge 3: RESP
    chk("wr_rsp_psel", psel, 4'h0);
    chk("wr_rsp_penable", penable, 1'b0);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_slverr", rsp_slverr, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    chk("wr_rsp_held", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    chk("wr_rsp_consumed", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // ---------------- read with 3 wait states
    pready = 1'b0;
    prdata = 32'hCAFE_BABE;
    set_cmd(32'h0000_3008, 1'b0, 32'h0, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();                      // SETUP
    chk("rd_setup_psel", psel, 4'b1000);
    chk("rd_setup_pstrb", pstrb, 4'h0);
    chk("rd_setup_pwrite", pwrite, 1'b0);
    tick();                      // first ACCESS cycle
    for (int i = 0; i < 4; i++) begin
      chk("rd_acc_psel", psel, 4'b1000);
      chk("rd_acc_penable", penable, 1'b1);
      chk("rd_acc_paddr", paddr, 32'h0000_3008);
      if (i == 3) pready = 1'b1;
      tick();
    end
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_psel", psel, 4'h0);
    chk("rd_rsp_rdata", rsp_rdata, 32'hCAFE_BABE);
    chk("rd_rsp_slverr", rsp_slverr, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    pready = 1'b0;

    // ---------------- timeout
    set_cmd(32'h0000_0010, 1'b0, 32'h0, 4'hF, 3'b001);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("to_setup_psel", psel, 4'b0001);
    tick();
    acc_cycles = 0;
    while (penable === 1'b1 && acc_cycles < 40) begin
      acc_cycles++;
      tick();
    end
    chk("to_access_cycles", acc_cycles, 16);
    chk("to_psel", psel, 4'h0);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_slverr", rsp_slverr, 1'b1);
    chk("to_rsp_timeout", rsp_timeout, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---------------- misaligned write
    set_cmd(32'h0000_0002, 1'b1, 32'h1234_5678, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mis_psel", psel, 4'h0);
    chk("mis_paddr_kept", paddr, 32'h0000_0010);
    chk("mis_rsp_valid", rsp_valid, 1'b1);
    chk("mis_rsp_slverr", rsp_slverr, 1'b1);
    chk("mis_rsp_timeout", rsp_timeout, 1'b0);
    tick();
    chk("mis_no_bus", psel, 4'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---------------- back-pressure: 5 pushes with rsp_ready low
    pready = 1'b1;
    n_rsp = 0;
    prdata = rd_tab[0];
    for (int i = 0; i < 5; i++) begin
      set_cmd(addr_tab[i], 1'b0, 32'h0, 4'hF, 3'b000);
      chk("bp_ready_before_push", cmd_ready, 1'b1);
      tick();
    end
    set_cmd(32'h0000_0500, 1'b0, 32'h0, 4'hF, 3'b000);
    chk("bp_full_ready", cmd_ready, 1'b0);
    activity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (psel !== 4'h0 || cmd_ready !== 1'b0) activity = 1'b1;
    end
    chk("bp_stalled", activity, 1'b0);
    chk("bp_first_rsp_valid", rsp_valid, 1'b1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 80 && n_rsp < 5; i++) begin
      if (psel !== 4'h0 && penable === 1'b0)
        chk("bp_paddr_order", paddr, addr_tab[n_rsp]);
      if (rsp_valid === 1'b1) begin
        chk("bp_rdata_order", rsp_rdata, rd_tab[n_rsp]);
        chk("bp_slverr", rsp_slverr, 1'b0);
        n_rsp++;
      end
      if (n_rsp < 5) prdata = rd_tab[n_rsp];
      tick();
    end
    chk("bp_rsp_count", n_rsp, 5);
    activity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (psel !== 4'h0 || rsp_valid !== 1'b0) activity = 1'b1;
    end
    chk("bp_no_sixth", activity, 1'b0);

    // ---------------- reset during ACCESS with 3 queued
    pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(addr_tab[i], 1'b1, 32'hA0A0_0000 + i, 4'hF, 3'b000);
      tick();
    end
    cmd_valid = 1'b0;
    chk("rst_mid_in_access", penable, 1'b1);
    preset = 1'b1;
    #1;
    chk("rst_mid_psel", psel, 4'h0);
    chk("rst_mid_penable", penable, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    tick();
    preset = 1'b0;
    pready = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (psel !== 4'h0 || rsp_valid !== 1'b0) activity = 1'b1;
    end
    chk("rst_mid_quiet", activity, 1'b0);
    set_cmd(32'h0000_2000, 1'b1, 32'h5A5A_5A5A, 4'h3, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_new_psel", psel, 4'b0100);
    chk("rst_new_paddr", paddr, 32'h0000_2000);
    chk("rst_new_pstrb", pstrb, 4'h3);
    tick();
    tick();
    chk("rst_new_rsp_valid", rsp_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
